// File: rtl/cordic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cordic_pkg
//  Purpose  : Shared constants for the iterative CORDIC engine. Holds the
//             arctangent table, the mode encodings, the quadrant angle, the
//             quadrant codes and the FSM state encodings.
//  Revision : 1.0  initial release
// ============================================================================
package cordic_pkg;

    // Number of entries in the arctangent table (max micro-rotations).
    localparam int ATAN_N = 24;

    // Width of the iteration index / counter (covers 0..ATAN_N).
    localparam int IDX_W = 5;

    // round(atan(2^-i) * 2^31 / pi): binary angle where 2^32 is one full turn.
    localparam logic [31:0] ATAN_TAB32 [0:ATAN_N-1] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
    };

    // Per-transaction mode encodings.
    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // +90 degrees as a 32-bit binary angle; narrowed to AW in the core.
    localparam logic [31:0] ANG90_32 = 32'h4000_0000;

    // Top two angle bits identifying the two obtuse quadrants.
    localparam logic [1:0] QUAD_POS_OBTUSE = 2'b01;   // (+90, +180)
    localparam logic [1:0] QUAD_NEG_OBTUSE = 2'b10;   // [-180, -90)

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cordic_atan_rom
//  Purpose  : Combinational arctangent lookup. Maps iteration index i to
//             atan(2^-i) as an AW-bit binary angle (+180 deg = 2^(AW-1)),
//             rounded to nearest. Indices beyond the table return 0.
//             AW must be in 2..32.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [AW-1:0]    atan_o
);

    localparam int SHIFT = 32 - AW;

    logic [31:0] w_raw;

    // Table fetch; out-of-range indices read as zero angle.
    always_comb begin
        w_raw = 32'd0;
        if (int'(idx_i) < ATAN_N) begin
            w_raw = ATAN_TAB32[idx_i];
        end
    end

    // Table entries are positive and far below 2^31, so a plain add of half
    // an output LSB before the shift gives round-to-nearest without overflow.
    generate
        if (SHIFT > 0) begin : g_round
            assign atan_o = AW'((w_raw + (32'd1 << (SHIFT - 1))) >> SHIFT);
        end else begin : g_exact
            assign atan_o = w_raw[AW-1:0];
        end
    endgenerate

endmodule : cordic_atan_rom
`default_nettype wire

// File: rtl/cordic_iter_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cordic_iter_engine
//  Purpose  : Iterative CORDIC core, one micro-rotation per clock.
//             Rotation mode rotates (x,y) by z; vectoring mode returns
//             magnitude (times gain K) and atan2(y,x). A quadrant
//             pre-rotation extends coverage to the full +/-180 deg range.
//             valid/ready handshakes on both sides; gain is not compensated.
//             Legal: 1 <= ITERS <= 24, ITERS <= DW, AW <= 32.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 20,
    parameter int ITERS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode_in,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] y_in,
    input  logic signed [AW-1:0] z_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x_out,
    output logic signed [DW-1:0] y_out,
    output logic signed [AW-1:0] z_out
);

    // Two guard bits keep K*sqrt(2)*full-scale inside the datapath.
    localparam int XW = DW + 2;

    localparam logic [AW-1:0]          ANG90   = AW'(ANG90_32 >> (32 - AW));
    localparam logic [IDX_W-1:0]       LAST    = IDX_W'(ITERS - 1);
    localparam logic signed [XW-1:0]   SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0]   SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    logic [1:0]              state_q, state_d;
    logic                    mode_q;
    logic [IDX_W-1:0]        cnt_q;
    logic signed [XW-1:0]    x_q, y_q;
    logic [AW-1:0]           z_q;
    logic signed [DW-1:0]    x_out_q, y_out_q;
    logic [AW-1:0]           z_out_q;

    logic signed [XW-1:0]    x_ext, y_ext;
    logic signed [XW-1:0]    pre_x, pre_y;
    logic [AW-1:0]           pre_z;
    logic signed [XW-1:0]    x_sh, y_sh;
    logic signed [XW-1:0]    x_nxt, y_nxt;
    logic [AW-1:0]           z_nxt;
    logic [AW-1:0]           atan_i;
    logic                    d_pos;

    function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end
        return v[DW-1:0];
    endfunction

    cordic_atan_rom #(
        .AW (AW)
    ) u_atan_rom (
        .idx_i  (cnt_q),
        .atan_o (atan_i)
    );

    assign x_ext = {{2{x_in[DW-1]}}, x_in};
    assign y_ext = {{2{y_in[DW-1]}}, y_in};

    // Quadrant pre-rotation: folds the operand into the +/-90 deg convergence range.
    always_comb begin
        pre_x = x_ext;
        pre_y = y_ext;
        pre_z = z_in;
        if (mode_in == MODE_ROT) begin
            case (z_in[AW-1 -: 2])
                QUAD_POS_OBTUSE: begin
                    pre_x = -y_ext;
                    pre_y = x_ext;
                    pre_z = z_in - ANG90;
                end
                QUAD_NEG_OBTUSE: begin
                    pre_x = y_ext;
                    pre_y = -x_ext;
                    pre_z = z_in + ANG90;
                end
                default: ;
            endcase
        end else begin
            pre_z = '0;
            if (x_in[DW-1]) begin
                if (!y_in[DW-1]) begin
                    pre_x = y_ext;
                    pre_y = -x_ext;
                    pre_z = ANG90;
                end else begin
                    pre_x = -y_ext;
                    pre_y = x_ext;
                    pre_z = -ANG90;
                end
            end
        end
    end

    // One shift-add micro-rotation; direction driven by z sign or y sign.
    always_comb begin
        x_sh  = x_q >>> cnt_q;
        y_sh  = y_q >>> cnt_q;
        d_pos = (mode_q == MODE_ROT) ? !z_q[AW-1] : y_q[XW-1];
        if (d_pos) begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_i;
        end else begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + atan_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)      state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: if (out_ready)     state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from the state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath: load on accept, iterate in RUN, capture saturated result on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_ROT;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode_in;
                        x_q    <= pre_x;
                        y_q    <= pre_y;
                        z_q    <= pre_z;
                        cnt_q  <= '0;
                    end
                end
                ST_RUN: begin
                    x_q   <= x_nxt;
                    y_q   <= y_nxt;
                    z_q   <= z_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        x_out_q <= sat(x_nxt);
                        y_out_q <= sat(y_nxt);
                        z_out_q <= z_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_out = x_out_q;
    assign y_out = y_out_q;
    assign z_out = z_out_q;

endmodule : cordic_iter_engine
`default_nettype wire
